// File: rtl/chunk_gather_packer_pkg.sv
// chunk_gather_packer_pkg: state type and width helper for the chunk gather packer.
package chunk_gather_packer_pkg;
    `include "chunk_defs.vh"

    typedef enum logic {
        S_FILL = ST_FILL,
        S_FULL = ST_FULL
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/chunk_defs.vh
// chunk_defs: FSM state codes and count-width macro shared by the chunk packer files.
`ifndef CHUNK_DEFS_VH
`define CHUNK_DEFS_VH
localparam logic ST_FILL = 1'b0;
localparam logic ST_FULL = 1'b1;
`define CHUNK_CW(n) $clog2((n)+1)
`endif

// File: rtl/chunk_gather_packer_slot.sv
// chunk_slot: one chunk-wide assembly register; clear wins over write.
module chunk_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_we,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= '0;
        else if (i_clr)
            r_q <= '0;
        else if (i_we)
            r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

// File: rtl/chunk_gather_packer.sv
// chunk_gather_packer: gathers CHUNK_SIZE-bit chunks into CHUNKS-slot words with
// an assembly stage and an output register so input keeps flowing under backpressure.
`include "chunk_defs.vh"
module chunk_gather_packer
    import chunk_gather_packer_pkg::*;
#(
    parameter int CHUNKS     = 4,
    parameter int CHUNK_SIZE = 8,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [CHUNK_SIZE-1:0]             in_data,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [CHUNKS*CHUNK_SIZE-1:0]      out_data,
    output logic [`CHUNK_CW(CHUNKS)-1:0]      out_count
);
    localparam int IW = idx_w(CHUNKS);
    localparam int CW = `CHUNK_CW(CHUNKS);
    localparam int WW = CHUNKS * CHUNK_SIZE;
    localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

    state_t          r_state, w_state_nxt;
    logic            r_alive;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_hold_cnt;
    logic            r_out_valid;
    logic [WW-1:0]   r_out_data;
    logic [CW-1:0]   r_out_count;

    logic            w_acc, w_last, w_can, w_load, w_hold;
    logic [IW-1:0]   w_slot;
    logic [CW-1:0]   w_cur_cnt;
    logic [CHUNKS-1:0] w_we;
    logic [WW-1:0]   w_q, w_word;

    assign in_ready  = r_alive && (r_state == S_FILL);
    assign w_acc     = in_valid && in_ready;
    assign w_last    = w_acc && (r_idx == LAST_IDX || in_last);
    assign w_can     = !r_out_valid || out_ready;
    assign w_slot    = MSB_FIRST ? LAST_IDX - r_idx : r_idx;
    assign w_cur_cnt = CW'(r_idx) + CW'(1);

    // The completing chunk is merged combinationally so the word can leave on the same edge.
    for (genvar g = 0; g < CHUNKS; g++) begin : slot_gen
        assign w_we[g] = w_acc && (w_slot == IW'(g));
        chunk_slot #(.W(CHUNK_SIZE)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .i_we  (w_we[g]),
            .i_clr (w_load),
            .i_d   (in_data),
            .o_q   (w_q[g*CHUNK_SIZE +: CHUNK_SIZE])
        );
        assign w_word[g*CHUNK_SIZE +: CHUNK_SIZE] = w_we[g] ? in_data : w_q[g*CHUNK_SIZE +: CHUNK_SIZE];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_hold      = 1'b0;
        if (r_state == S_FILL) begin
            if (w_last) begin
                if (w_can) begin
                    w_load = 1'b1;
                end else begin
                    w_hold      = 1'b1;
                    w_state_nxt = S_FULL;
                end
            end
        end else if (out_ready) begin
            w_load      = 1'b1;
            w_state_nxt = S_FILL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FILL;
            r_alive    <= 1'b0;
            r_idx      <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_alive <= 1'b1;
            if (w_acc)
                r_idx <= w_last ? '0 : r_idx + IW'(1);
            if (w_hold)
                r_hold_cnt <= w_cur_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= (r_state == S_FULL) ? w_q : w_word;
            r_out_count <= (r_state == S_FULL) ? r_hold_cnt : w_cur_cnt;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
endmodule
